// File: rtl/spi_master_n_pkg.sv
// Shared definitions for the SPI master: register map, CTRL field positions,
// FSM states and the effective-length helper.
package spi_master_n_pkg;

    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CTRL = 1'b1;

    localparam int unsigned CTRL_LEN_LSB = 0;
    localparam int unsigned CTRL_LEN_MSB = 5;
    localparam int unsigned CTRL_CPOL    = 8;
    localparam int unsigned CTRL_CPHA    = 9;
    localparam int unsigned CTRL_CSM_LSB = 16;
    localparam int unsigned CTRL_CSM_MSB = 23;
    localparam int unsigned CTRL_OVR     = 30;
    localparam int unsigned CTRL_BUSY    = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } spi_state_e;

    // A LEN of 0, or one wider than the shifter, selects the full word.
    function automatic logic [6:0] eff_len(input logic [5:0] len, input int unsigned dw);
        if (len == 6'd0 || 32'(len) > dw) return 7'(dw);
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_master_n_clkgen.sv
// Half-period tick generator: o_tick pulses once every CLK_DIV+1 cycles,
// with a synchronous restart so a transfer's first tick is exactly CLK_DIV+1 cycles out.
module spi_clkgen #(
    parameter int unsigned CLK_DIV = 49
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLK_DIV));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_n.sv
// Wishbone SPI master with runtime CPOL/CPHA/length, MISO readback, CS mask,
// overrun status and a done interrupt. Two registers: DATA (adr 0), CTRL (adr 1).
module spi_master_n
    import spi_master_n_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NCS     = 8,
    parameter int unsigned CLK_DIV = 49,
    parameter logic        CLK_POL = 1'b0
) (
    input  logic           wb_clk,
    input  logic           wb_rst,
    input  logic           wb_cyc,
    input  logic           wb_stb,
    input  logic           wb_we,
    input  logic           wb_adr,
    input  logic [31:0]    wb_dat_i,
    output logic [31:0]    wb_dat_o,
    output logic           wb_ack,
    output logic           spi_clk,
    output logic           spi_mosi,
    input  logic           spi_miso,
    output logic [NCS-1:0] spi_cs,
    output logic           irq
);

    spi_state_e r_state, w_state_nxt;

    logic              r_ack;
    logic [31:0]       r_dat_o;
    logic [5:0]        r_len_cfg;
    logic              r_cpol_cfg;
    logic              r_cpha_cfg;
    logic [7:0]        r_csm_cfg;
    logic              r_ovr;

    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rxsh;
    logic [DATA_W-1:0] r_rx;
    logic              r_mosi;
    logic              r_sclk;
    logic [NCS-1:0]    r_cs;
    logic              r_irq;
    logic [6:0]        r_hcnt;
    logic [6:0]        r_len2;
    logic              r_cpha;

    logic              w_access, w_wr, w_start, w_ovr_set, w_ctrl_wr;
    logic              w_tick, w_edge, w_done, w_lead, w_last;
    logic              w_shift_out, w_sample, w_busy;
    logic [6:0]        w_len_eff;
    logic [DATA_W-1:0] w_tx_aligned;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_access  = wb_cyc & wb_stb & ~r_ack;
    assign w_wr      = w_access & wb_we;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_start   = w_wr & (wb_adr == ADR_DATA) & ~w_busy;
    assign w_ovr_set = w_wr & (wb_adr == ADR_DATA) & w_busy;
    assign w_ctrl_wr = w_wr & (wb_adr == ADR_CTRL);
    assign w_unused  = ^wb_dat_i;

    assign w_len_eff    = eff_len(r_len_cfg, DATA_W);
    assign w_tx_aligned = wb_dat_i[DATA_W-1:0] << (7'(DATA_W) - w_len_eff);

    spi_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .i_clk    (wb_clk),
        .i_rst_n  (wb_rst),
        .i_restart(w_start),
        .o_tick   (w_tick)
    );

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Edge k (1..2*LEN) occurs at the start of SHIFT half-period k; the final
    // SHIFT tick carries no edge, leaving SCLK at CPOL into TRAIL.
    always_comb begin
        w_state_nxt = r_state;
        w_edge      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_LEAD;
            ST_LEAD:  if (w_tick) begin
                          w_state_nxt = ST_SHIFT;
                          w_edge      = 1'b1;
                      end
            ST_SHIFT: if (w_tick) begin
                          if (r_hcnt == r_len2) w_state_nxt = ST_TRAIL;
                          else                  w_edge      = 1'b1;
                      end
            ST_TRAIL: if (w_tick) begin
                          w_state_nxt = ST_IDLE;
                          w_done      = 1'b1;
                      end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_lead      = ~r_hcnt[0];
    assign w_last      = (r_hcnt + 7'd1 == r_len2);
    assign w_shift_out = w_edge & (r_cpha ? w_lead : (~w_lead & ~w_last));
    assign w_sample    = w_edge & (r_cpha ? ~w_lead : w_lead);

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_tx   <= '0;
            r_rxsh <= '0;
            r_rx   <= '0;
            r_mosi <= 1'b0;
            r_sclk <= CLK_POL;
            r_cs   <= '1;
            r_irq  <= 1'b0;
            r_hcnt <= '0;
            r_len2 <= '0;
            r_cpha <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_start) begin
                r_len2 <= w_len_eff << 1;
                r_cpha <= r_cpha_cfg;
                r_sclk <= r_cpol_cfg;
                r_cs   <= ~r_csm_cfg[NCS-1:0];
                r_hcnt <= '0;
                r_rxsh <= '0;
                // CPHA=0 presents the first bit during LEAD; CPHA=1 waits for the leading edge.
                if (!r_cpha_cfg) begin
                    r_mosi <= w_tx_aligned[DATA_W-1];
                    r_tx   <= w_tx_aligned << 1;
                end else begin
                    r_tx   <= w_tx_aligned;
                end
            end else begin
                if (r_state == ST_IDLE) r_sclk <= r_cpol_cfg;
                if (w_edge) begin
                    r_sclk <= ~r_sclk;
                    r_hcnt <= r_hcnt + 7'd1;
                end
                if (w_shift_out) begin
                    r_mosi <= r_tx[DATA_W-1];
                    r_tx   <= r_tx << 1;
                end
                if (w_sample) r_rxsh <= (r_rxsh << 1) | DATA_W'(spi_miso);
                if (w_done) begin
                    r_cs  <= '1;
                    r_rx  <= r_rxsh;
                    r_irq <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_len_cfg  <= '0;
            r_cpol_cfg <= CLK_POL;
            r_cpha_cfg <= 1'b0;
            r_csm_cfg  <= 8'h01;
            r_ovr      <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_len_cfg  <= wb_dat_i[CTRL_LEN_MSB:CTRL_LEN_LSB];
            r_cpol_cfg <= wb_dat_i[CTRL_CPOL];
            r_cpha_cfg <= wb_dat_i[CTRL_CPHA];
            r_csm_cfg  <= wb_dat_i[CTRL_CSM_MSB:CTRL_CSM_LSB];
            if (wb_dat_i[CTRL_OVR]) r_ovr <= 1'b0;
        end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (wb_adr == ADR_CTRL) begin
            w_rdata[CTRL_LEN_MSB:CTRL_LEN_LSB] = r_len_cfg;
            w_rdata[CTRL_CPOL]                 = r_cpol_cfg;
            w_rdata[CTRL_CPHA]                 = r_cpha_cfg;
            w_rdata[CTRL_CSM_MSB:CTRL_CSM_LSB] = r_csm_cfg;
            w_rdata[CTRL_OVR]                  = r_ovr;
            w_rdata[CTRL_BUSY]                 = w_busy;
        end else begin
            w_rdata[DATA_W-1:0] = r_rx;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access) r_dat_o <= w_rdata;
        end
    end

    assign wb_ack   = r_ack;
    assign wb_dat_o = r_dat_o;
    assign spi_clk  = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs   = r_cs;
    assign irq      = r_irq;

endmodule
